// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 transmit arbiter and its helpers.
// Holds the controller state encoding and the byte width.
package rs232_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_TX = 2'd1,
        WRITE   = 2'd2,
        GAP     = 2'd3
    } state_t;

endpackage

// File: rtl/rs232_tx_arbiter_if.sv
// Requester / transmitter bundle for rs232_tx_arbiter.
// Optional macro RS232_ARB_LOCK_EN adds the per-client req_last vector.
// modport master: the arbiter side; modport slave: clients plus transmitter.
interface rs232_tx_arbiter_if
    import rs232_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
);

    logic [N_REQ-1:0]        req;
    logic [BYTE_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        req_ack;
    logic [BYTE_W-1:0]       tx_data;
    logic                    tx_flag;
    logic                    tx_wr;
    logic [IDX_W-1:0]        grant_idx;
    logic                    busy;
`ifdef RS232_ARB_LOCK_EN
    logic [N_REQ-1:0]        req_last;
`endif

    modport master (
        input  req, req_data, tx_flag,
`ifdef RS232_ARB_LOCK_EN
        input  req_last,
`endif
        output req_ack, tx_data, tx_wr, grant_idx, busy
    );

    modport slave (
        output req, req_data, tx_flag,
`ifdef RS232_ARB_LOCK_EN
        output req_last,
`endif
        input  req_ack, tx_data, tx_wr, grant_idx, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: searches last+1, last+2, ...
// (wrapping modulo N_REQ) and returns the first requesting index.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    int               cand;
    logic [IDX_W-1:0] sel;

    // First requester after 'last' in circular order; last itself is checked last.
    always_comb begin
        winner = last;
        valid  = 1'b0;
        cand   = 0;
        sel    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last) + i) % N_REQ;
            sel  = IDX_W'(cand);
            if (!valid && req[sel]) begin
                winner = sel;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one RS232 transmitter byte port among
// N_REQ requesters. Each grant latches a byte, acks the client for one
// cycle, waits for tx_flag, strobes tx_wr once, then spends a dead cycle.
// Optional macro RS232_ARB_LOCK_EN: multi-byte messages lock the arbiter
// to a client until it sends a byte flagged with req_last.
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    rs232_tx_arbiter_if.master  bus
);

    state_t              state, state_nx;
    logic [N_REQ-1:0]    ack_q, ack_nx;
    logic                tx_wr_q, tx_wr_nx;
    logic [BYTE_W-1:0]   data_q, data_nx;
    logic [IDX_W-1:0]    grant_q, grant_nx;

    logic [N_REQ-1:0]    cand_req;
    logic [IDX_W-1:0]    winner;
    logic                win_vld;
    logic [BYTE_W-1:0]   win_byte;

`ifdef RS232_ARB_LOCK_EN
    logic                lock_q, lock_nx;

    // While locked only the previously granted client may compete.
    always_comb begin
        cand_req = bus.req;
        if (lock_q) begin
            cand_req = bus.req & (N_REQ'(1) << grant_q);
        end
    end
`else
    assign cand_req = bus.req;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (cand_req),
        .last   (grant_q),
        .winner (winner),
        .valid  (win_vld)
    );

    // Byte lane of the current round-robin winner.
    always_comb begin
        win_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                win_byte = bus.req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // Next-state and next-output logic; ack and tx_wr default to idle so they pulse.
    always_comb begin
        state_nx = state;
        ack_nx   = '0;
        tx_wr_nx = 1'b0;
        data_nx  = data_q;
        grant_nx = grant_q;
`ifdef RS232_ARB_LOCK_EN
        lock_nx  = lock_q;
`endif
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    data_nx  = win_byte;
                    grant_nx = winner;
                    ack_nx   = N_REQ'(1) << winner;
`ifdef RS232_ARB_LOCK_EN
                    lock_nx  = ~bus.req_last[winner];
`endif
                    state_nx = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (bus.tx_flag) begin
                    tx_wr_nx = 1'b1;
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                state_nx = GAP;
            end
            GAP: begin
                // Dead cycle lets the transmitter drop tx_flag before the next grant.
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins over every state and drops any pending byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ack_q   <= '0;
            tx_wr_q <= 1'b0;
            data_q  <= '0;
            grant_q <= IDX_W'(N_REQ - 1);
`ifdef RS232_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            ack_q   <= ack_nx;
            tx_wr_q <= tx_wr_nx;
            data_q  <= data_nx;
            grant_q <= grant_nx;
`ifdef RS232_ARB_LOCK_EN
            lock_q  <= lock_nx;
`endif
        end
    end

    assign bus.req_ack   = ack_q;
    assign bus.tx_wr     = tx_wr_q;
    assign bus.tx_data   = data_q;
    assign bus.grant_idx = grant_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Self-checking bench for rs232_tx_arbiter (N_REQ=4): directed scenarios
// followed by randomized traffic against a transaction-level model.
// Define RS232_ARB_LOCK_EN to also exercise the message-lock feature.
module tb_rs232_tx_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;

    rs232_tx_arbiter_if #(.N_REQ(N), .IDX_W(2)) bus ();

    rs232_tx_arbiter #(.N_REQ(N), .IDX_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Client byte queues; head is the byte currently presented.
    logic [7:0] q  [N][$];
    bit         ql [N][$];

    int         ack_log[$];
    int         gi_log[$];
    logic [7:0] tx_log[$];
    int         txt_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_clients();
        for (int i = 0; i < N; i++) begin
            bus.req[i]            = (q[i].size() > 0);
            bus.req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
`ifdef RS232_ARB_LOCK_EN
            bus.req_last[i]       = (ql[i].size() > 0) ? ql[i][0] : 1'b1;
`endif
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int ack_index(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) if (a[i]) return i;
        return -1;
    endfunction

    // Round-robin rule: first requester after 'last', wrapping modulo N.
    function automatic int rr_pred(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            ql[i].delete();
        end
        drive_clients();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs the client model until every queue is drained and the arbiter is idle.
    // late_c >= 0 adds one byte for that client when the first ack is seen.
    task automatic serve(input int max_cyc, input int late_c, input logic [7:0] late_b,
                         input bit late_last);
        int cyc = 0;
        bit late_done = (late_c < 0);
        int w;
        ack_log.delete(); gi_log.delete(); tx_log.delete(); txt_log.delete();
        drive_clients();
        while (cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ack != '0) begin
                w = ack_index(bus.req_ack);
                ack_log.push_back(w);
                gi_log.push_back(int'(bus.grant_idx));
                if (q[w].size() > 0) begin
                    void'(q[w].pop_front());
                    if (ql[w].size() > 0) void'(ql[w].pop_front());
                end
                if (!late_done) begin
                    q[late_c].push_back(late_b);
                    ql[late_c].push_back(late_last);
                    late_done = 1'b1;
                end
            end
            if (bus.tx_wr) begin
                tx_log.push_back(bus.tx_data);
                txt_log.push_back(cyc);
            end
            drive_clients();
            if (late_done && all_empty() && !bus.busy) break;
        end
        chk("serve_done", (cyc < max_cyc), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int wr_cnt;
        int last;
        int last_wr;
        int w;
        int pred;
        int waitc[N];
        logic [7:0] exp_tx[$];
        logic [7:0] rr_exp[5];
        int gi_exp[5];

        reset       = 1'b1;
        bus.tx_flag = 1'b0;
        bus.req     = '0;
        bus.req_data = '0;
`ifdef RS232_ARB_LOCK_EN
        bus.req_last = '1;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ack", bus.req_ack, 0);
        chk("rst_wr", bus.tx_wr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant", bus.grant_idx, 3);
        chk("rst_data", bus.tx_data, 0);
        reset = 1'b0;

        // Single request with transmitter ready.
        bus.tx_flag = 1'b1;
        q[0].push_back(8'h41);
        drive_clients();
        @(negedge clk);
        chk("t1_ack", bus.req_ack, 4'b0001);
        chk("t1_busy", bus.busy, 1);
        chk("t1_grant", bus.grant_idx, 0);
        chk("t1_wr_early", bus.tx_wr, 0);
        void'(q[0].pop_front());
        drive_clients();
        @(negedge clk);
        chk("t1_wr", bus.tx_wr, 1);
        chk("t1_data", bus.tx_data, 8'h41);
        chk("t1_ack_low", bus.req_ack, 0);
        @(negedge clk);
        chk("t1_wr_once", bus.tx_wr, 0);
        chk("t1_gap_busy", bus.busy, 1);
        @(negedge clk);
        chk("t1_idle", bus.busy, 0);

        // Round-robin with all four clients requesting.
        do_reset();
        bus.tx_flag = 1'b1;
        q[0].push_back(8'h30); q[0].push_back(8'h30);
        q[1].push_back(8'h31);
        q[2].push_back(8'h32);
        q[3].push_back(8'h33);
        rr_exp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30};
        gi_exp = '{0, 1, 2, 3, 0};
        serve(80, -1, 8'h00, 1'b1);
        chk("rr_count", tx_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < tx_log.size()) chk($sformatf("rr_byte%0d", k), tx_log[k], rr_exp[k]);
            if (k < gi_log.size()) chk($sformatf("rr_grant%0d", k), gi_log[k], gi_exp[k]);
            if (k > 0 && k < txt_log.size())
                chk($sformatf("rr_space%0d", k), txt_log[k] - txt_log[k-1], 4);
        end

        // Backpressure: transmitter not ready for 20 cycles.
        bus.tx_flag = 1'b0;
        q[0].push_back(8'h5A);
        drive_clients();
        @(negedge clk);
        chk("bp_ack", bus.req_ack, 4'b0001);
        void'(q[0].pop_front());
        drive_clients();
        wr_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tx_wr) wr_cnt++;
        end
        chk("bp_no_wr", wr_cnt, 0);
        chk("bp_busy", bus.busy, 1);
        bus.tx_flag = 1'b1;
        wr_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.tx_wr) begin
                wr_cnt++;
                chk("bp_data", bus.tx_data, 8'h5A);
            end
        end
        chk("bp_one_wr", wr_cnt, 1);
        chk("bp_idle", bus.busy, 0);

        // Late arrival: client 1 raises req while client 2 is being served.
        q[2].push_back(8'h62);
        serve(60, 1, 8'h61, 1'b1);
        chk("late_n", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            chk("late_first", ack_log[0], 2);
            chk("late_second", ack_log[1], 1);
        end
        if (tx_log.size() == 2) begin
            chk("late_b0", tx_log[0], 8'h62);
            chk("late_b1", tx_log[1], 8'h61);
            chk("late_space", txt_log[1] - txt_log[0], 4);
        end else begin
            chk("late_txn", tx_log.size(), 2);
        end

        // Reset while waiting for the transmitter.
        bus.tx_flag = 1'b0;
        q[0].push_back(8'h77);
        drive_clients();
        @(negedge clk);
        chk("mr_ack", bus.req_ack, 4'b0001);
        void'(q[0].pop_front());
        drive_clients();
        @(negedge clk);
        reset = 1'b1;
        bus.tx_flag = 1'b1;
        @(negedge clk);
        chk("mr_wr", bus.tx_wr, 0);
        chk("mr_ack0", bus.req_ack, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_grant", bus.grant_idx, 3);
        chk("mr_data", bus.tx_data, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_dropped", bus.tx_wr, 0);
        q[0].push_back(8'h55);
        serve(40, -1, 8'h00, 1'b1);
        chk("mr_after_n", tx_log.size(), 1);
        if (tx_log.size() == 1) chk("mr_after_b", tx_log[0], 8'h55);
        if (ack_log.size() == 1) chk("mr_after_c", ack_log[0], 0);

`ifdef RS232_ARB_LOCK_EN
        // Client 3 sends a three-byte message while client 0 also requests.
        do_reset();
        bus.tx_flag = 1'b1;
        q[3].push_back(8'hC1); ql[3].push_back(1'b0);
        q[3].push_back(8'hC2); ql[3].push_back(1'b0);
        q[3].push_back(8'hC3); ql[3].push_back(1'b1);
        serve(100, 0, 8'hA0, 1'b1);
        chk("lk_n", ack_log.size(), 4);
        if (ack_log.size() == 4) begin
            chk("lk_c0", ack_log[0], 3);
            chk("lk_c1", ack_log[1], 3);
            chk("lk_c2", ack_log[2], 3);
            chk("lk_c3", ack_log[3], 0);
        end
        if (tx_log.size() == 4) begin
            chk("lk_b2", tx_log[2], 8'hC3);
            chk("lk_b3", tx_log[3], 8'hA0);
        end
`endif

        // Randomized traffic against the transaction-level model.
        do_reset();
        last    = N - 1;
        last_wr = -100;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        exp_tx.delete();
        bus.tx_flag = 1'b1;
        for (int cyc = 0; cyc < 3600; cyc++) begin
            @(negedge clk);
            if (bus.req_ack != '0) begin
                chk("r_onehot", $countones(bus.req_ack), 1);
                chk("r_ack_wr", bus.tx_wr, 0);
                w    = ack_index(bus.req_ack);
                pred = rr_pred(bus.req, last);
                chk("r_winner", w, pred);
                chk("r_grant", bus.grant_idx, w);
                if (q[w].size() > 0) begin
                    chk("r_latch", bus.tx_data, q[w][0]);
                    exp_tx.push_back(q[w][0]);
                    void'(q[w].pop_front());
                    if (ql[w].size() > 0) void'(ql[w].pop_front());
                end else begin
                    chk("r_ack_noreq", 0, 1);
                end
                chk("r_fair", (waitc[w] <= N - 1), 1);
                waitc[w] = 0;
                for (int j = 0; j < N; j++) if (j != w && bus.req[j]) waitc[j]++;
                last = w;
            end
            if (bus.tx_wr) begin
                chk("r_wr_flag", bus.tx_flag, 1);
                chk("r_wr_space", (cyc - last_wr >= 4), 1);
                last_wr = cyc;
                if (exp_tx.size() > 0) chk("r_wr_data", bus.tx_data, exp_tx.pop_front());
                else chk("r_wr_extra", 0, 1);
            end
            if (cyc < 3000) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 7) == 0 && q[i].size() < 3) begin
                        q[i].push_back(8'($urandom));
                        ql[i].push_back(1'b1);
                    end
                end
                bus.tx_flag = ($urandom_range(0, 9) < 7);
            end else begin
                bus.tx_flag = 1'b1;
                if (all_empty() && exp_tx.size() == 0 && !bus.busy) break;
            end
            drive_clients();
        end
        chk("r_drained", (all_empty() && exp_tx.size() == 0), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
